// File: rtl/mult_share_arbiter.sv
// Round-robin front end sharing one start/done multiplier among N_REQ engines.
// Grants one job at a time, waits for done or timeout, returns a one-cycle response.
module mult_share_arbiter #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_a,
    input  logic [N_REQ*WIDTH-1:0] req_b,
    output logic [N_REQ-1:0]       gnt,
    output logic [N_REQ-1:0]       rsp_valid,
    output logic [2*WIDTH-1:0]     rsp_product,
    output logic                   rsp_err,
    output logic                   busy,
    output logic                   mul_start,
    output logic [WIDTH-1:0]       mul_multiplicand,
    output logic [WIDTH-1:0]       mul_multiplier,
    input  logic [2*WIDTH-1:0]     mul_product,
    input  logic                   mul_done
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t               state_q;
    logic [IW-1:0]        ptr_q;
    logic [IW-1:0]        owner_q;
    logic [CW-1:0]        cnt_q;
    logic [N_REQ-1:0]     gnt_q;
    logic [N_REQ-1:0]     rsp_valid_q;
    logic [2*WIDTH-1:0]   rsp_product_q;
    logic                 rsp_err_q;
    logic                 mul_start_q;
    logic [WIDTH-1:0]     mul_a_q;
    logic [WIDTH-1:0]     mul_b_q;

    logic                 pick_vld;
    logic [IW-1:0]        pick_idx;
    logic [WIDTH-1:0]     pick_a;
    logic [WIDTH-1:0]     pick_b;
    logic [IW-1:0]        ptr_d;

    // Scan downward so the requester closest to the pointer is written last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req[(int'(ptr_q) + k) % N_REQ]) begin
                pick_vld = 1'b1;
                pick_idx = IW'((int'(ptr_q) + k) % N_REQ);
            end
        end
    end

    assign pick_a = req_a[int'(pick_idx) * WIDTH +: WIDTH];
    assign pick_b = req_b[int'(pick_idx) * WIDTH +: WIDTH];
    assign ptr_d  = IW'((int'(owner_q) + 1) % N_REQ);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            owner_q       <= '0;
            cnt_q         <= '0;
            gnt_q         <= '0;
            rsp_valid_q   <= '0;
            rsp_product_q <= '0;
            rsp_err_q     <= 1'b0;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
        end else begin
            gnt_q       <= '0;
            rsp_valid_q <= '0;
            mul_start_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        owner_q   <= pick_idx;
                        mul_a_q   <= pick_a;
                        mul_b_q   <= pick_b;
                        gnt_q     <= N_REQ'(1) << pick_idx;
                        cnt_q     <= '0;
                        rsp_err_q <= 1'b0;
                        // A zero operand makes the product trivially zero.
                        if (pick_a != '0 && pick_b != '0) begin
                            mul_start_q <= 1'b1;
                            state_q     <= WAIT;
                        end else begin
                            rsp_product_q <= '0;
                            state_q       <= RESP;
                        end
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (mul_done) begin
                        rsp_product_q <= mul_product;
                        rsp_err_q     <= 1'b0;
                        state_q       <= RESP;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        rsp_product_q <= '0;
                        rsp_err_q     <= 1'b1;
                        state_q       <= RESP;
                    end
                end
                RESP: begin
                    rsp_valid_q <= N_REQ'(1) << owner_q;
                    ptr_q       <= ptr_d;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt              = gnt_q;
    assign rsp_valid        = rsp_valid_q;
    assign rsp_product      = rsp_product_q;
    assign rsp_err          = rsp_err_q;
    assign busy             = (state_q != IDLE);
    assign mul_start        = mul_start_q;
    assign mul_multiplicand = mul_a_q;
    assign mul_multiplier   = mul_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: multiplier stub plus a transaction-level
// round-robin model (pointer, operand table, expected latency per job).
module tb_mult_share_arbiter;

    localparam int N = 4;
    localparam int W = 16;
    localparam int T = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     gnt;
    logic [N-1:0]     rsp_valid;
    logic [2*W-1:0]   rsp_product;
    logic             rsp_err;
    logic             busy;
    logic             mul_start;
    logic [W-1:0]     mul_multiplicand;
    logic [W-1:0]     mul_multiplier;
    logic [2*W-1:0]   mul_product;
    logic             mul_done;

    logic             stub_done = 1'b0;
    logic             inj_done = 1'b0;
    logic [2*W-1:0]   stub_p = '0;
    int               stub_cnt = 0;
    bit               stub_run = 1'b0;
    int               stub_lat = 2;
    bit               stub_never = 1'b0;

    logic [W-1:0]     op_a [N];
    logic [W-1:0]     op_b [N];
    int               ptr_m = 0;
    int               checks = 0;
    int               errors = 0;

    mult_share_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_a            (req_a),
        .req_b            (req_b),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_product      (rsp_product),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .mul_start        (mul_start),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_product      (mul_product),
        .mul_done         (mul_done)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_a[i*W +: W] = op_a[i];
            req_b[i*W +: W] = op_b[i];
        end
    end

    // Multiplier stub: done is visible stub_lat+2 cycles after the start cycle.
    always @(posedge clk) begin
        stub_done <= 1'b0;
        if (reset) begin
            stub_run <= 1'b0;
            stub_p   <= '0;
        end else if (mul_start) begin
            stub_run <= 1'b1;
            stub_cnt <= stub_lat;
            stub_p   <= mul_multiplicand * mul_multiplier;
        end else if (stub_run) begin
            if (stub_never) begin
                stub_run <= 1'b0;
            end else if (stub_cnt == 0) begin
                stub_done <= 1'b1;
                stub_run  <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign mul_done    = stub_done | inj_done;
    assign mul_product = stub_p;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        tick();
        tick();
        reset = 1'b0;
        ptr_m = 0;
    endtask

    // Serve one job from the currently held req mask and check it end to end.
    task automatic serve();
        int          idx;
        int          n;
        int          exp_lat;
        bit          nz;
        bit          exp_err;
        logic [63:0] exp_p;
        idx = -1;
        for (int k = 0; k < N; k++) begin
            int j;
            j = (ptr_m + k) % N;
            if (idx < 0 && req[j]) idx = j;
        end
        if (idx < 0) begin
            chk("model_no_req", 0, 1);
            return;
        end
        n = 0;
        while (gnt == '0 && n < 20) begin
            tick();
            n++;
        end
        if (gnt == '0) begin
            chk("gnt_wait", 0, 1);
            return;
        end
        chk("gnt_lat", n, 1);
        chk("gnt", gnt, 64'd1 << idx);
        chk("mul_a", mul_multiplicand, op_a[idx]);
        chk("mul_b", mul_multiplier, op_b[idx]);
        nz = (op_a[idx] != 0) && (op_b[idx] != 0);
        chk("mul_start", mul_start, nz);
        chk("busy_job", busy, 1);
        exp_err = nz && stub_never;
        exp_lat = !nz ? 1 : (stub_never ? T + 1 : stub_lat + 4);
        exp_p   = exp_err ? 64'd0 : 64'(op_a[idx]) * 64'(op_b[idx]);
        req[idx] = 1'b0;
        n = 0;
        while (rsp_valid == '0 && n < T + 40) begin
            tick();
            n++;
        end
        if (rsp_valid == '0) begin
            chk("rsp_wait", 0, 1);
            return;
        end
        chk("rsp_valid", rsp_valid, 64'd1 << idx);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_product", rsp_product, exp_p);
        chk("rsp_lat", n, exp_lat);
        ptr_m = (idx + 1) % N;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int mask;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        do_reset();
        reset = 1'b1;
        tick();
        chk("rst_gnt", gnt, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_product", rsp_product, 0);
        chk("rst_err", rsp_err, 0);
        chk("rst_busy", busy, 0);
        chk("rst_start", mul_start, 0);
        chk("rst_ops", {mul_multiplicand, mul_multiplier}, 0);
        reset = 1'b0;

        // Single job
        op_a[0] = 16'h0008; op_b[0] = 16'h0010;
        stub_lat = 3;
        req = 4'b0001;
        serve();

        // All four from reset, then 0 and 2 together after the wrap
        do_reset();
        op_a[0] = 16'd3;      op_b[0] = 16'd5;
        op_a[1] = 16'd7;      op_b[1] = 16'd9;
        op_a[2] = 16'h00FF;   op_b[2] = 16'd2;
        op_a[3] = 16'h1234;   op_b[3] = 16'h0010;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) serve();
        chk("ptr_wrap", ptr_m, 0);
        req = 4'b0101;
        serve();
        serve();

        // Zero-skip
        op_a[1] = 16'h0000; op_b[1] = 16'hABCD;
        req = 4'b0010;
        serve();

        // Timeout, then a normal job
        stub_never = 1'b1;
        op_a[2] = 16'd5; op_b[2] = 16'd6;
        req = 4'b0100;
        serve();
        stub_never = 1'b0;
        op_a[3] = 16'd11; op_b[3] = 16'd13;
        req = 4'b1000;
        serve();

        // Max operands; done arriving on the last WAIT cycle beats timeout
        op_a[0] = 16'hFFFF; op_b[0] = 16'hFFFF;
        stub_lat = T - 3;
        req = 4'b0001;
        serve();
        stub_lat = 2;

        // Stray done while idle
        inj_done = 1'b1;
        tick();
        inj_done = 1'b0;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid != '0 || busy) cnt++;
            tick();
        end
        chk("late_done_idle", cnt, 0);

        // Reset during WAIT with the pointer away from zero
        op_a[3] = 16'd9; op_b[3] = 16'd9;
        stub_lat = 30;
        req = 4'b1000;
        tick();
        chk("wr_gnt", gnt, 4'b1000);
        req = '0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ptr_m = 0;
        chk("wr_busy", busy, 0);
        chk("wr_rsp_valid", rsp_valid, 0);
        chk("wr_ops", {mul_multiplicand, mul_multiplier}, 0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid != '0) cnt++;
            tick();
        end
        chk("wr_no_rsp", cnt, 0);
        stub_lat = 2;
        op_a[2] = 16'h0102; op_b[2] = 16'h0304;
        req = 4'b1100;
        serve();
        serve();

        // Randomized rounds
        for (int r = 0; r < 30; r++) begin
            mask = int'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                op_a[i] = ($urandom_range(0, 7) == 0) ? 16'h0 : W'($urandom);
                op_b[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : W'($urandom);
            end
            stub_lat = int'($urandom_range(0, 20));
            req = N'(mask);
            for (int i = 0; i < $countones(N'(mask)); i++) serve();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
